// File: rtl/ahb3lite_n_mem.sv
// ---------------------------------------------------------------------------
// ahb3lite_n_mem
//   AHB3-Lite slave in front of a single-port, word-organised on-chip memory.
//   It handles single and burst transfers with byte, halfword and word
//   accesses. Legal accesses complete with zero wait states and an OKAY
//   response. Every beat is decoded from its own HADDR, so HBURST does not
//   affect decoding. HPROT is ignored.
//
//   Optional feature, selected with macro AHB3LITE_ERR_RESP_EN:
//     defined   - out-of-range, oversized (HSIZE>2) and misaligned transfers
//                 get a two-cycle ERROR response and never touch memory.
//     undefined - HRESP is tied to 0 and HREADYOUT to 1. Addresses wrap
//                 modulo MEM_DEPTH words. HSIZE>2 acts as a word access.
//                 Misaligned low address bits are ignored.
//
// Parameters
//   MEM_SIZE    memory word width in bits (32; must equal HDATA_SIZE)
//   MEM_DEPTH   number of memory words
//   HADDR_SIZE  address bus width
//   HDATA_SIZE  data bus width
//
// Ports
//   HCLK       bus clock; all logic runs on the rising edge
//   HRESETn    asynchronous active-low reset
//   HSEL       slave select from the decoder
//   HADDR      byte address (address phase)
//   HWDATA     write data (data phase)
//   HRDATA     read data (data phase); zero when no read is in its data phase
//   HWRITE     1 = write, 0 = read
//   HSIZE      0 = byte, 1 = halfword, 2 = word
//   HBURST     burst type; accepted but not used
//   HPROT      protection; accepted but not used
//   HTRANS     0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ
//   HREADY     system-wide ready; an address phase is sampled only when 1
//   HREADYOUT  slave ready
//   HRESP      0 = OKAY, 1 = ERROR
// ---------------------------------------------------------------------------
module ahb3lite_n_mem #(
  parameter int MEM_SIZE   = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  // Byte lanes per memory word. The lane decode below assumes 32-bit words.
  localparam int LANES = 4;

  // Memory array. Reads are asynchronous from the registered index, so a
  // write that commits on the edge that starts a read's data phase is already
  // visible to that read.
  logic [MEM_SIZE-1:0] mem [MEM_DEPTH];

  logic             accept;
  logic             bad_xfer;
  logic [LANES-1:0] lane_en;

  // Data-phase state: the address phase is captured as a word index plus a
  // lane mask, which is all the data phase needs from HADDR and HSIZE.
  logic             wr_valid_d, wr_valid_q;
  logic             rd_valid_d, rd_valid_q;
  logic [IDX_W-1:0] idx_d, idx_q;
  logic [LANES-1:0] be_d, be_q;

  assign accept = HSEL & HREADY & HTRANS[1];

  // Lanes touched by this access. Misaligned low bits are ignored, so a
  // halfword selects its pair of lanes from HADDR[1] only.
  always_comb begin
    lane_en = '0;
    case (HSIZE)
      3'd0:    lane_en = 4'b0001 << HADDR[1:0];
      3'd1:    lane_en = HADDR[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

`ifdef AHB3LITE_ERR_RESP_EN
  localparam logic [HADDR_SIZE-1:0] SPAN = HADDR_SIZE'(MEM_DEPTH * LANES);

  always_comb begin
    bad_xfer = (HADDR >= SPAN)
            || (HSIZE > 3'd2)
            || ((HSIZE == 3'd1) && HADDR[0])
            || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  end
`else
  assign bad_xfer = 1'b0;
`endif

  // The previous data phase ends on every edge where HREADY is 1. If HREADY
  // is 0, the data phase is extended and its contents are held.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    wr_valid_d = wr_valid_q;
    rd_valid_d = rd_valid_q;
    idx_d      = idx_q;
    be_d       = be_q;
    if (HREADY) begin
      wr_valid_d = accept & ~bad_xfer & HWRITE;
      rd_valid_d = accept & ~bad_xfer & ~HWRITE;
      if (accept) begin
        idx_d = HADDR[IDX_W+1:2];
        be_d  = lane_en;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      idx_q      <= '0;
      be_q       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples the values from before the edge regardless of block order.
      wr_valid_q <= wr_valid_d;
      rd_valid_q <= rd_valid_d;
      idx_q      <= idx_d;
      be_q       <= be_d;
    end
  end

  // NOTE: the memory array is deliberately left out of reset. Reset clears
  // wr_valid_q, which is enough to drop a write that is still pending.
  always_ff @(posedge HCLK) begin
    if (wr_valid_q && HREADY) begin
      for (int i = 0; i < LANES; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HRDATA = rd_valid_q ? mem[idx_q] : '0;

`ifdef AHB3LITE_ERR_RESP_EN
  // Two-cycle ERROR response: ERR1 stalls the bus, and ERR2 releases it
  // while still signalling ERROR. A transfer presented during ERR2 is
  // accepted like any other.
  typedef enum logic [1:0] {
    IDLE_OK = 2'd0,
    ERR1    = 2'd1,
    ERR2    = 2'd2
  } state_e;

  state_e state_d, state_q;
  logic   hreadyout_c, hresp_c;

  always_comb begin
    state_d     = state_q;
    hreadyout_c = 1'b1;
    hresp_c     = 1'b0;
    case (state_q)
      IDLE_OK: begin
        if (accept && bad_xfer) state_d = ERR1;
      end
      ERR1: begin
        hreadyout_c = 1'b0;
        hresp_c     = 1'b1;
        state_d     = ERR2;
      end
      ERR2: begin
        hresp_c = 1'b1;
        state_d = (accept && bad_xfer) ? ERR1 : IDLE_OK;
      end
      default: state_d = IDLE_OK;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= IDLE_OK;
    else          state_q <= state_d;
  end

  assign HREADYOUT = hreadyout_c;
  assign HRESP     = hresp_c;

  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HTRANS[0]};
`else
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  // Upper address bits are not decoded, so accesses wrap modulo MEM_DEPTH.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HTRANS[0], HADDR[HADDR_SIZE-1:IDX_W+2]};
`endif

endmodule

// File: tb/tb_ahb3lite_n_mem.sv
// ---------------------------------------------------------------------------
// tb_ahb3lite_n_mem
//   Bench for ahb3lite_n_mem. A byte-array model of the memory tracks the
//   transfer that is in its data phase and any error sequence. One process
//   compares HREADYOUT, HRESP and HRDATA against the model on every falling
//   edge. Directed sequences add literal expectations, and randomized traffic
//   follows them. HREADY is fed back from HREADYOUT, as in a one-slave system.
// ---------------------------------------------------------------------------
module tb_ahb3lite_n_mem;

  localparam int DEPTH = 256;
  localparam int SPAN  = DEPTH * 4;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic [31:0] HRDATA;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = '0;
  logic [2:0]  HBURST = '0;
  logic [3:0]  HPROT = '0;
  logic [1:0]  HTRANS = '0;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;

  assign HREADY = HREADYOUT;

  ahb3lite_n_mem #(
    .MEM_SIZE  (32),
    .MEM_DEPTH (DEPTH),
    .HADDR_SIZE(32),
    .HDATA_SIZE(32)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HWDATA   (HWDATA),
    .HRDATA   (HRDATA),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HBURST   (HBURST),
    .HPROT    (HPROT),
    .HTRANS   (HTRANS),
    .HREADY   (HREADY),
    .HREADYOUT(HREADYOUT),
    .HRESP    (HRESP)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  model_mem [SPAN];
  bit          ph_valid = 0;      // legal transfer in its data phase
  bit          ph_write = 0;
  logic [31:0] ph_addr = '0;
  logic [2:0]  ph_size = '0;
  int          err_phase = 0;     // 0 none, 1 first error cycle, 2 second
  bit          cmp_en = 0;

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
`ifdef AHB3LITE_ERR_RESP_EN
    if (a >= 32'(SPAN)) return 1'b1;
    if (s > 3'd2) return 1'b1;
    if ((a % (32'd1 << s)) != 0) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int b;
    b = int'((a & ~32'd3) % 32'(SPAN));
    return {model_mem[b+3], model_mem[b+2], model_mem[b+1], model_mem[b]};
  endfunction

  task automatic model_commit(input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
    int n, base, b;
    n    = (s > 3'd2) ? 4 : (1 << s);
    base = (int'(a) / n) * n;
    for (int k = 0; k < n; k++) begin
      b = (base + k) % SPAN;
      model_mem[b] = wd[8*(b%4) +: 8];
    end
  endtask

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ph_valid  = 0;
      err_phase = 0;
    end else if (err_phase == 1) begin
      err_phase = 2;                    // bus stalled: nothing is sampled
    end else begin
      if (ph_valid && ph_write) model_commit(ph_addr, ph_size, HWDATA);
      ph_valid  = 0;
      err_phase = 0;
      if (HSEL && HTRANS[1]) begin
        if (is_err(HADDR, HSIZE)) err_phase = 1;
        else begin
          ph_valid = 1;
          ph_write = HWRITE;
          ph_addr  = HADDR;
          ph_size  = HSIZE;
        end
      end
    end
  end

  always @(negedge HCLK) begin
    if (cmp_en) begin
      check("hreadyout", 32'(HREADYOUT), (err_phase == 1) ? 32'd0 : 32'd1);
      check("hresp",     32'(HRESP),     (err_phase != 0) ? 32'd1 : 32'd0);
      check("hrdata",    HRDATA, (ph_valid && !ph_write) ? model_word(ph_addr) : 32'd0);
    end
  end

  // ---------------- driver ----------------
  logic [31:0] pending_wdata = '0;

  // Presents one address phase and drives HWDATA for the previous beat. It
  // returns 1 ns after the edge that accepts the address, which is the start
  // of that beat's data phase.
  task automatic beat(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    int waits;
    waits  = 0;
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = wr;
    HADDR  = addr;
    HSIZE  = size;
    HBURST = 3'($urandom);
    HPROT  = 4'($urandom);
    HWDATA = pending_wdata;
    pending_wdata = wdata;
    forever begin
      @(negedge HCLK);
      if (HREADY === 1'b1) break;
      waits++;
      if (waits > 8) begin
        check("hready_timeout", 32'(HREADY), 32'd1);
        break;
      end
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_beat();
    beat(1'b0, 2'd0, 1'b0, 32'd0, 3'd0, 32'd0);
  endtask

  task automatic idle_inputs();
    HSEL   = 1'b0;
    HTRANS = 2'd0;
    HWDATA = pending_wdata;
    pending_wdata = '0;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    beat(1'b1, 2'd2, 1'b1, a, 3'd2, d);
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    beat(1'b1, 2'd2, 1'b0, a, 3'd2, 32'd0);
    check(name, HRDATA, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < SPAN; i++) model_mem[i] = 8'h00;

    // Reset state
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hresp",     32'(HRESP),     32'd0);
    check("rst_hrdata",    HRDATA,         32'd0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    cmp_en  = 1'b1;

    // Fill every word so that any later read has a known model value
    for (int i = 0; i < DEPTH; i++) write_word(32'(i * 4), $urandom);
    idle_beat();

    // Word write, then word read
    write_word(32'h10, 32'hDEADBEEF);
    idle_beat();
    read_check("word_rd", 32'h10, 32'hDEADBEEF);
    check("word_rd_ready", 32'(HREADYOUT), 32'd1);
    idle_beat();

    // Byte and halfword writes with junk in the unselected lanes
    write_word(32'h20, 32'h11223344);
    beat(1'b1, 2'd2, 1'b1, 32'h23, 3'd0, 32'hAAFFFFFF);
    beat(1'b1, 2'd2, 1'b1, 32'h20, 3'd1, 32'hFFFF5566);
    idle_beat();
    read_check("lane_rd", 32'h20, 32'hAA225566);
    idle_beat();
    check("model_lane", model_word(32'h20), 32'hAA225566);

    // INCR4 burst with one BUSY after beat 2; the BUSY data is junk
    beat(1'b1, 2'd2, 1'b1, 32'h40, 3'd2, 32'd1);
    beat(1'b1, 2'd3, 1'b1, 32'h44, 3'd2, 32'd2);
    beat(1'b1, 2'd1, 1'b1, 32'h48, 3'd2, 32'hBADBAD00);
    check("busy_resp", 32'(HRESP), 32'd0);
    beat(1'b1, 2'd3, 1'b1, 32'h48, 3'd2, 32'd3);
    beat(1'b1, 2'd3, 1'b1, 32'h4C, 3'd2, 32'd4);
    idle_beat();
    read_check("burst_rd0", 32'h40, 32'd1);
    read_check("burst_rd1", 32'h44, 32'd2);
    read_check("burst_rd2", 32'h48, 32'd3);
    read_check("burst_rd3", 32'h4C, 32'd4);
    idle_beat();

    // Back-to-back write then read of the same word
    write_word(32'h8, 32'hCAFE0001);
    read_check("b2b_rd", 32'h8, 32'hCAFE0001);
    check("b2b_ready", 32'(HREADYOUT), 32'd1);
    idle_beat();

`ifdef AHB3LITE_ERR_RESP_EN
    // Out-of-range write: ERROR in two cycles, memory untouched
    write_word(32'h0, 32'h0BADF00D);
    write_word(32'h400, 32'h12345678);
    check("err1_ready", 32'(HREADYOUT), 32'd0);
    check("err1_resp",  32'(HRESP),     32'd1);
    idle_inputs();
    @(posedge HCLK);
    #1;
    check("err2_ready", 32'(HREADYOUT), 32'd1);
    check("err2_resp",  32'(HRESP),     32'd1);
    @(posedge HCLK);
    #1;
    check("err_done_resp", 32'(HRESP), 32'd0);
    read_check("err_word0", 32'h0, 32'h0BADF00D);
    idle_beat();
`else
    // Address wraps modulo the memory size
    write_word(32'h0, 32'h0BADF00D);
    write_word(32'h400, 32'h12345678);
    idle_beat();
    read_check("wrap_word0", 32'h0, 32'h12345678);
    idle_beat();
`endif

    // Reset during a write data phase: the write is dropped
    write_word(32'h60, 32'h11111111);
    write_word(32'h60, 32'h22222222);
    idle_inputs();
    #2;
    HRESETn = 1'b0;
    #1;
    check("rstw_ready",  32'(HREADYOUT), 32'd1);
    check("rstw_resp",   32'(HRESP),     32'd0);
    check("rstw_hrdata", HRDATA,         32'd0);
    @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    read_check("rstw_keep", 32'h60, 32'h11111111);

    // Reset during a read data phase clears HRDATA at once
    idle_inputs();
    #2;
    HRESETn = 1'b0;
    #1;
    check("rstr_hrdata", HRDATA, 32'd0);
    @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic        sel, wr;
      logic [1:0]  trans;
      logic [31:0] addr;
      logic [2:0]  size;
      sel   = ($urandom_range(0, 9) != 0);
      trans = 2'($urandom_range(0, 3));
      wr    = 1'($urandom);
      addr  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(SPAN, 2*SPAN-1))
                                          : 32'($urandom_range(0, SPAN-1));
      size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
                                          : 3'($urandom_range(0, 2));
      beat(sel, trans, wr, addr, size, $urandom);
    end
    idle_beat();
    idle_beat();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
